// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module  : morse_pkg
// Brief   : Shared state encodings, default thresholds and speed modes for
//           the Morse timing/decoder slice.
// Rev     : 1.0  initial release
// ============================================================================
package morse_pkg;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_mark  = 2'd1;
    localparam logic [1:0] c_space = 2'd2;

    localparam int c_cnt_w_dflt         = 12;
    localparam int c_dot_max_ms_dflt    = 200;
    localparam int c_letter_gap_ms_dflt = 600;
    localparam int c_word_gap_ms_dflt   = 1400;

    // Encodings understood by the timer chain's mode input.
    typedef enum logic [1:0] {
        SPEED_NORMAL = 2'd0,
        SPEED_FAST   = 2'd1,
        SPEED_SLOW   = 2'd2,
        SPEED_TEST   = 2'd3
    } speed_mode_e;

    typedef struct packed {
        logic dot;
        logic dash;
        logic letter_end;
        logic word_end;
    } sym_evt_t;

endpackage
`default_nettype wire

// File: rtl/ms_duration_counter.sv
`default_nettype none
// ============================================================================
// Module  : ms_duration_counter
// Brief   : Saturating millisecond duration counter with synchronous clear.
// Rev     : 1.0  initial release
// ============================================================================
module ms_duration_counter
    import morse_pkg::*;
#(
    parameter int CNT_W = c_cnt_w_dflt
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_tick,
    output logic [CNT_W-1:0] o_count,
    output logic [CNT_W-1:0] o_count_inc
);

    localparam logic [CNT_W-1:0] c_max = '1;

    logic [CNT_W-1:0] r_count;

    // Saturated next value; exposed so the owner can act on a same-cycle tick.
    assign o_count_inc = (r_count == c_max) ? r_count : r_count + 1'b1;
    assign o_count     = r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_tick) begin
            r_count <= o_count_inc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/morse_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : morse_timing_ctrl
// Brief   : Gates/programs the ms timer and turns key mark/space durations
//           into one-cycle dot, dash, letter_end and word_end events.
// Rev     : 1.0  initial release
// ============================================================================
module morse_timing_ctrl
    import morse_pkg::*;
#(
    parameter int CNT_W         = c_cnt_w_dflt,
    parameter int DOT_MAX_MS    = c_dot_max_ms_dflt,
    parameter int LETTER_GAP_MS = c_letter_gap_ms_dflt,
    parameter int WORD_GAP_MS   = c_word_gap_ms_dflt
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       tick,
    input  logic [1:0] speed,
    output logic       timer_enable,
    output logic [1:0] timer_mode,
    output logic       timer_reconfig,
    output logic       dot,
    output logic       dash,
    output logic       letter_end,
    output logic       word_end,
    output logic       busy
);

    localparam logic [CNT_W-1:0] c_dot_max    = CNT_W'(DOT_MAX_MS);
    localparam logic [CNT_W-1:0] c_letter_gap = CNT_W'(LETTER_GAP_MS);
    localparam logic [CNT_W-1:0] c_word_gap   = CNT_W'(WORD_GAP_MS);

    logic [1:0]       r_state;
    logic             r_letter_done;
    logic [1:0]       r_speed_q;

    logic [1:0]       w_state_nxt;
    logic             w_letter_done_nxt;
    logic             w_speed_chg;
    logic             w_clear;
    logic             w_inc;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_inc;
    logic [CNT_W-1:0] w_final;
    sym_evt_t         w_evt;

    ms_duration_counter #(
        .CNT_W (CNT_W)
    ) u_dur_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_tick      (w_inc),
        .o_count     (w_count),
        .o_count_inc (w_count_inc)
    );

    assign w_speed_chg = (speed != r_speed_q);
    // A tick arriving with the release still belongs to the mark.
    assign w_final     = tick ? w_count_inc : w_count;

    always_comb begin
        w_state_nxt       = r_state;
        w_letter_done_nxt = r_letter_done;
        w_clear           = 1'b0;
        w_inc             = 1'b0;
        w_evt             = '0;

        if (w_speed_chg) begin
            w_state_nxt = c_idle;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                c_idle: begin
                    if (key) begin
                        w_state_nxt       = c_mark;
                        w_clear           = 1'b1;
                        w_letter_done_nxt = 1'b0;
                    end
                end
                c_mark: begin
                    if (!key) begin
                        w_evt.dot   = (w_final < c_dot_max);
                        w_evt.dash  = !(w_final < c_dot_max);
                        w_state_nxt = c_space;
                        w_clear     = 1'b1;
                    end else begin
                        w_inc = tick;
                    end
                end
                c_space: begin
                    // A new press resumes the letter; a coincident tick is dropped.
                    if (key) begin
                        w_state_nxt       = c_mark;
                        w_clear           = 1'b1;
                        w_letter_done_nxt = 1'b0;
                    end else if (tick) begin
                        w_inc = 1'b1;
                        if (w_count_inc == c_word_gap) begin
                            w_evt.word_end = 1'b1;
                            w_state_nxt    = c_idle;
                            w_clear        = 1'b1;
                        end else if (w_count_inc == c_letter_gap && !r_letter_done) begin
                            w_evt.letter_end  = 1'b1;
                            w_letter_done_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_idle;
                    w_clear     = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_idle;
            r_letter_done  <= 1'b0;
            r_speed_q      <= 2'd0;
            timer_enable   <= 1'b0;
            timer_reconfig <= 1'b0;
            dot            <= 1'b0;
            dash           <= 1'b0;
            letter_end     <= 1'b0;
            word_end       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_letter_done  <= w_letter_done_nxt;
            r_speed_q      <= speed;
            timer_enable   <= (w_state_nxt != c_idle);
            timer_reconfig <= w_speed_chg;
            dot            <= w_evt.dot;
            dash           <= w_evt.dash;
            letter_end     <= w_evt.letter_end;
            word_end       <= w_evt.word_end;
            busy           <= (w_state_nxt != c_idle);
        end
    end

    assign timer_mode = r_speed_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_morse_timing_ctrl
// Brief   : Directed + random bench for morse_timing_ctrl with a cycle model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_morse_timing_ctrl;

    localparam int DOT_MAX  = 200;
    localparam int LETTER   = 600;
    localparam int WORD     = 1400;
    localparam int SAT      = 4095;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] speed = 2'd0;
    logic       timer_enable;
    logic [1:0] timer_mode;
    logic       timer_reconfig;
    logic       dot;
    logic       dash;
    logic       letter_end;
    logic       word_end;
    logic       busy;

    morse_timing_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .key            (key),
        .tick           (tick),
        .speed          (speed),
        .timer_enable   (timer_enable),
        .timer_mode     (timer_mode),
        .timer_reconfig (timer_reconfig),
        .dot            (dot),
        .dash           (dash),
        .letter_end     (letter_end),
        .word_end       (word_end),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural reference: phase 0 = waiting, 1 = key down, 2 = key up.
    int   m_phase = 0;
    int   m_ticks = 0;
    bit   m_letter_sent = 1'b0;
    int   m_spd = 0;

    logic [8:0] exp_vec;
    logic [8:0] obs_vec;
    logic       cur_key = 1'b0;
    logic [1:0] cur_spd = 2'd0;
    int n_dot, n_dash, n_letter, n_word, n_reconf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_counts();
        n_dot = 0; n_dash = 0; n_letter = 0; n_word = 0; n_reconf = 0;
    endtask

    task automatic step(input logic k, input logic [1:0] s, input logic r);
        int  t;
        bit  e_rc, e_dot, e_dash, e_le, e_we;
        @(negedge clk);
        cur_key = k;
        cur_spd = s;
        key     = k;
        speed   = s;
        rst     = r;
        tick    = (cyc % 4 == 3);
        e_rc = 0; e_dot = 0; e_dash = 0; e_le = 0; e_we = 0;
        if (r) begin
            m_phase = 0; m_ticks = 0; m_letter_sent = 0; m_spd = 0;
        end else if (int'(s) != m_spd) begin
            m_spd = int'(s); e_rc = 1; m_phase = 0; m_ticks = 0;
        end else if (m_phase == 0) begin
            if (k) begin m_phase = 1; m_ticks = 0; m_letter_sent = 0; end
        end else if (m_phase == 1) begin
            t = m_ticks + (tick ? 1 : 0);
            if (t > SAT) t = SAT;
            if (!k) begin
                if (t < DOT_MAX) e_dot = 1; else e_dash = 1;
                m_phase = 2; m_ticks = 0;
            end else begin
                m_ticks = t;
            end
        end else begin
            if (k) begin
                m_phase = 1; m_ticks = 0; m_letter_sent = 0;
            end else if (tick) begin
                m_ticks++;
                if (m_ticks == WORD) begin
                    e_we = 1; m_phase = 0; m_ticks = 0;
                end else if (m_ticks == LETTER && !m_letter_sent) begin
                    e_le = 1; m_letter_sent = 1;
                end
            end
        end
        exp_vec = {m_phase != 0, 2'(m_spd), e_rc, e_dot, e_dash, e_le, e_we, m_phase != 0};
        @(posedge clk);
        #1;
        cyc++;
        obs_vec = {timer_enable, timer_mode, timer_reconfig, dot, dash, letter_end, word_end, busy};
        n_dot    += int'(dot);
        n_dash   += int'(dash);
        n_letter += int'(letter_end);
        n_word   += int'(word_end);
        n_reconf += int'(timer_reconfig);
        check($sformatf("cycle%0d_outputs", cyc), 32'(obs_vec), 32'(exp_vec));
    endtask

    task automatic run_ticks(input logic k, input int n);
        int seen = 0;
        while (seen < n) begin
            step(k, cur_spd, 1'b0);
            if (tick) seen++;
        end
    endtask

    task automatic run_cycles(input logic k, input int n);
        for (int i = 0; i < n; i++) step(k, cur_spd, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 6000 && m_phase != 0; i++) step(1'b0, cur_spd, 1'b0);
        check("drain_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_counts();
        // Reset and idle
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b1);
        check("reset_outputs", 32'(obs_vec), 32'd0);
        run_cycles(1'b0, 100);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_timer_enable", 32'(timer_enable), 32'd0);

        // 150-tick mark, letter gap, word gap
        clear_counts();
        step(1'b1, cur_spd, 1'b0);
        check("mark_timer_enable", 32'(timer_enable), 32'd1);
        run_ticks(1'b1, 150);
        step(1'b0, cur_spd, 1'b0);
        check("m150_dot", 32'(dot), 32'd1);
        check("m150_dot_count", 32'(n_dot), 32'd1);
        check("m150_dash_count", 32'(n_dash), 32'd0);
        run_ticks(1'b0, LETTER - 1);
        check("gap599_no_letter", 32'(n_letter), 32'd0);
        run_ticks(1'b0, 1);
        check("gap600_letter", 32'(letter_end), 32'd1);
        run_ticks(1'b0, WORD - LETTER - 1);
        check("gap1399_no_word", 32'(n_word), 32'd0);
        check("gap1399_busy", 32'(busy), 32'd1);
        run_ticks(1'b0, 1);
        check("gap1400_word", 32'(word_end), 32'd1);
        check("gap1400_busy_low", 32'(busy), 32'd0);
        check("gap1400_letter_once", 32'(n_letter), 32'd1);

        // Threshold marks: 200 -> dash, 199 -> dot, 0 -> dot
        clear_counts();
        step(1'b1, cur_spd, 1'b0);
        run_ticks(1'b1, DOT_MAX);
        step(1'b0, cur_spd, 1'b0);
        check("m200_dash", 32'(dash), 32'd1);
        check("m200_no_dot", 32'(n_dot), 32'd0);
        drain();
        clear_counts();
        step(1'b1, cur_spd, 1'b0);
        run_ticks(1'b1, DOT_MAX - 1);
        step(1'b0, cur_spd, 1'b0);
        check("m199_dot", 32'(dot), 32'd1);
        check("m199_no_dash", 32'(n_dash), 32'd0);
        drain();
        clear_counts();
        run_ticks(1'b0, 1);
        step(1'b1, cur_spd, 1'b0);
        step(1'b0, cur_spd, 1'b0);
        check("m0_dot", 32'(dot), 32'd1);
        drain();

        // Short space keeps the letter open
        clear_counts();
        step(1'b1, cur_spd, 1'b0);
        run_ticks(1'b1, 50);
        step(1'b0, cur_spd, 1'b0);
        run_ticks(1'b0, 300);
        step(1'b1, cur_spd, 1'b0);
        run_ticks(1'b1, 250);
        step(1'b0, cur_spd, 1'b0);
        check("seq_dot_count", 32'(n_dot), 32'd1);
        check("seq_dash_count", 32'(n_dash), 32'd1);
        check("seq_no_letter", 32'(n_letter), 32'd0);
        drain();

        // Speed change mid-mark discards the measurement
        clear_counts();
        step(1'b1, cur_spd, 1'b0);
        run_ticks(1'b1, 100);
        step(1'b1, 2'd2, 1'b0);
        check("spd_reconfig", 32'(timer_reconfig), 32'd1);
        check("spd_mode", 32'(timer_mode), 32'd2);
        check("spd_busy_low", 32'(busy), 32'd0);
        step(1'b0, cur_spd, 1'b0);
        check("spd_reconfig_1cyc", 32'(timer_reconfig), 32'd0);
        run_cycles(1'b0, 20);
        check("spd_no_symbol", 32'(n_dot + n_dash), 32'd0);
        check("spd_reconfig_count", 32'(n_reconf), 32'd1);

        // Saturating mark, then reset mid-space
        clear_counts();
        step(1'b1, cur_spd, 1'b0);
        run_ticks(1'b1, 5000);
        step(1'b0, cur_spd, 1'b0);
        check("sat_dash", 32'(dash), 32'd1);
        run_ticks(1'b0, 500);
        step(1'b0, cur_spd, 1'b1);
        check("rst_space_outputs", 32'(obs_vec), 32'd0);
        step(1'b0, cur_spd, 1'b0);
        run_cycles(1'b0, 4 * WORD);
        check("rst_space_no_word", 32'(n_word), 32'd0);

        // Random marks/spaces at arbitrary cycle offsets
        for (int it = 0; it < 5; it++) begin
            step(1'b1, cur_spd, 1'b0);
            run_cycles(1'b1, int'($urandom_range(1, 1000)));
            step(1'b0, cur_spd, 1'b0);
            run_cycles(1'b0, int'($urandom_range(1, 2000)));
            if ($urandom_range(0, 3) == 0) step(1'b0, 2'($urandom_range(0, 3)), 1'b0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
